// File: rtl/button_debounce_if.sv
// Button conditioner bus: raw levels in, debounced level/pulses/toggles out.
interface button_debounce_if #(
  parameter int WIDTH = 5
) ();
  logic [WIDTH-1:0] btn_in;
  logic [WIDTH-1:0] btn_stable;
  logic [WIDTH-1:0] btn_rise;
  logic [WIDTH-1:0] btn_fall;
  logic [WIDTH-1:0] btn_toggle;

  // Producer of raw levels and consumer of the cleaned outputs
  modport master (
    output btn_in,
    input  btn_stable,
    input  btn_rise,
    input  btn_fall,
    input  btn_toggle
  );

  // The debouncer itself
  modport slave (
    input  btn_in,
    output btn_stable,
    output btn_rise,
    output btn_fall,
    output btn_toggle
  );
endinterface

// File: rtl/button_debounce.sv
// Per-bit input conditioner: two-flop synchroniser, stability-window debounce,
// registered rise/fall pulses and a toggle latch that flips on every rise.
module button_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic          clk,
  input  logic          reset,
  button_debounce_if.slave bus
);

  // Last count value of the window; reaching it with a still-differing input
  // accepts the new level.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Two-flop synchroniser for the raw asynchronous pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;
      logic             r_rise;
      logic             r_fall;
      logic             r_toggle;

      // Debounce window: count consecutive cycles of disagreement, clear on
      // any return to the stable level, commit the new level when full.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
          r_rise   <= 1'b0;
          r_fall   <= 1'b0;
          r_toggle <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (r_sync2[gi] == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt != LP_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt    <= '0;
            r_stable <= r_sync2[gi];
            if (r_sync2[gi]) begin
              r_rise   <= 1'b1;
              r_toggle <= ~r_toggle;
            end else begin
              r_fall   <= 1'b1;
            end
          end
        end
      end

      assign bus.btn_stable[gi] = r_stable;
      assign bus.btn_rise[gi]   = r_rise;
      assign bus.btn_fall[gi]   = r_fall;
      assign bus.btn_toggle[gi] = r_toggle;
    end
  endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: a vector table, directed multi-cycle sequences and
// a randomized run, all checked against a window-based reference model.
module tb_button_debounce;
  localparam int W = 5;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_debounce_if #(.WIDTH(W)) bus ();

  button_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // The debounce logic sees btn_in delayed by two edges. A bit's level is
  // accepted when the last D samples it saw all disagree with its current
  // debounced level.
  logic [W-1:0] m_dly[$];
  logic [W-1:0] m_samp[$];
  logic [W-1:0] m_stable, m_rise, m_fall, m_tog;

  task automatic model_step(input logic rst, input logic [W-1:0] b);
    logic [W-1:0] s2;
    bit all_diff;
    if (rst) begin
      m_dly = '{'0, '0};
      m_samp.delete();
      m_stable = '0; m_rise = '0; m_fall = '0; m_tog = '0;
    end else begin
      s2 = m_dly.pop_front();
      m_dly.push_back(b);
      m_samp.push_back(s2);
      if (m_samp.size() > D) void'(m_samp.pop_front());
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_samp.size() == D) begin
          all_diff = 1'b1;
          foreach (m_samp[k]) if (m_samp[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[i] = ~m_stable[i];
            if (m_stable[i]) begin
              m_rise[i] = 1'b1;
              m_tog[i]  = ~m_tog[i];
            end else begin
              m_fall[i] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Captured DUT outputs after the most recent edge
  logic [W-1:0] o_st, o_ri, o_fa, o_tg;

  // One clock: drive inputs, advance the model at the edge, compare mid-cycle
  task automatic tick(input logic rst, input logic [W-1:0] b);
    reset = rst;
    bus.btn_in = b;
    @(posedge clk);
    model_step(rst, b);
    @(negedge clk);
    o_st = bus.btn_stable; o_ri = bus.btn_rise;
    o_fa = bus.btn_fall;   o_tg = bus.btn_toggle;
    chk("model_stable", o_st, m_stable);
    chk("model_rise",   o_ri, m_rise);
    chk("model_fall",   o_fa, m_fall);
    chk("model_toggle", o_tg, m_tog);
    if ((o_ri & o_fa) != '0) chk("rise_fall_exclusive", o_ri & o_fa, '0);
  endtask

  task automatic do_reset();
    tick(1'b1, '0);
    tick(1'b1, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic         rst;
    logic [W-1:0] btn;
    logic [W-1:0] st;
    logic [W-1:0] ri;
    logic [W-1:0] fa;
    logic [W-1:0] tg;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int n, input logic rst, input logic [W-1:0] btn,
                     input logic [W-1:0] st, input logic [W-1:0] ri,
                     input logic [W-1:0] fa, input logic [W-1:0] tg);
    vec_t v;
    v = '{rst: rst, btn: btn, st: st, ri: ri, fa: fa, tg: tg};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  int rise_cnt, fall_cnt, rise_at, rise3_at, rise4_at;
  logic [W-1:0] seen;
  logic [W-1:0] lvl;
  int hold[W];

  initial begin
    reset = 1'b1;
    bus.btn_in = '0;
    m_dly = '{'0, '0};
    m_stable = '0; m_rise = '0; m_fall = '0; m_tog = '0;

    // Reset with all inputs high, then release: fresh press of all bits,
    // followed by a full release.
    add(2, 1'b1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00);
    add(5, 1'b0, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00);
    add(1, 1'b0, 5'h1F, 5'h1F, 5'h1F, 5'h00, 5'h1F);
    add(3, 1'b0, 5'h1F, 5'h1F, 5'h00, 5'h00, 5'h1F);
    add(5, 1'b0, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h1F);
    add(1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h1F);
    add(2, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F);
    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].btn);
      chk($sformatf("vec%0d_stable", i), o_st, vecs[i].st);
      chk($sformatf("vec%0d_rise", i),   o_ri, vecs[i].ri);
      chk($sformatf("vec%0d_fall", i),   o_fa, vecs[i].fa);
      chk($sformatf("vec%0d_toggle", i), o_tg, vecs[i].tg);
    end

    // Clean press/release on bit 0
    do_reset();
    rise_cnt = 0; fall_cnt = 0;
    for (int t = 0; t < 32; t++) begin
      tick(1'b0, (t < 20) ? 5'b00001 : 5'b00000);
      if (t == 5) begin
        chk("press_stable_e5", o_st, 5'b00001);
        chk("press_rise_e5",   o_ri, 5'b00001);
      end
      if (t == 6) chk("press_rise_e6", o_ri, 5'b00000);
      if (t == 25) chk("release_fall_e5", o_fa, 5'b00001);
      rise_cnt += int'(o_ri[0]);
      fall_cnt += int'(o_fa[0]);
    end
    chk("press_rise_count", W'(rise_cnt), W'(1));
    chk("release_fall_count", W'(fall_cnt), W'(1));
    chk("release_toggle", o_tg, 5'b00001);

    // Bounce on bit 1: 1,0,1,0 two cycles each, then hold 1 from t=8
    do_reset();
    rise_cnt = 0; rise_at = -1;
    for (int t = 0; t < 20; t++) begin
      tick(1'b0, {3'b000, ((t >= 8) || ((t / 2) % 2 == 0)), 1'b0});
      if (t < 13) chk("bounce_quiet", o_st, 5'b00000);
      if (o_ri[1]) begin rise_cnt++; rise_at = t; end
    end
    chk("bounce_rise_count", W'(rise_cnt), W'(1));
    chk("bounce_rise_time", W'(rise_at), W'(13));

    // Short 3-cycle glitch on bit 2
    do_reset();
    seen = '0;
    for (int t = 0; t < 14; t++) begin
      tick(1'b0, (t < 3) ? 5'b00100 : 5'b00000);
      seen |= o_st | o_ri | o_fa;
    end
    chk("glitch_no_activity", seen, 5'b00000);

    // Two press/release cycles on bit 3 with bit 4 pressed alongside the first
    do_reset();
    rise3_at = -1; rise4_at = -2;
    for (int t = 0; t < 10; t++) begin
      tick(1'b0, 5'b11000);
      if (o_ri[3]) rise3_at = t;
      if (o_ri[4]) rise4_at = t;
    end
    chk("indep_rise_coincide", W'(rise3_at), W'(rise4_at));
    chk("indep_toggle_first", o_tg, 5'b11000);
    for (int t = 0; t < 10; t++) tick(1'b0, 5'b10000);
    for (int t = 0; t < 10; t++) tick(1'b0, 5'b11000);
    for (int t = 0; t < 10; t++) tick(1'b0, 5'b10000);
    chk("indep_toggle_second", o_tg, 5'b10000);
    chk("indep_stable_final", o_st, 5'b10000);

    // Reset on the edge where the bit-0 pulse would fire, input held high
    do_reset();
    for (int t = 0; t < 5; t++) tick(1'b0, 5'b00001);
    tick(1'b1, 5'b00001);
    chk("midreset_no_pulse", o_ri | o_st, 5'b00000);
    rise_at = -1;
    for (int t = 0; t < 10; t++) begin
      tick(1'b0, 5'b00001);
      if (o_ri[0]) rise_at = t;
    end
    chk("midreset_rise_time", W'(rise_at), W'(5));

    // Randomized per-bit hold lengths with occasional resets
    do_reset();
    lvl = '0;
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          lvl[i] = ~lvl[i];
          hold[i] = int'($urandom_range(1, 12));
        end
        hold[i]--;
      end
      tick(($urandom_range(0, 199) == 0), lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/button_debounce.md
# button_debounce

Input conditioner for the board's push-buttons and slide switches, the input-side counterpart of the LED blinking driver. Each raw, asynchronous, bouncing input bit is synchronised to `clk`, debounced by requiring a stable level for a programmable number of cycles, and presented as a clean level with one-cycle rise/fall pulses and a per-bit toggle latch. Downstream ALSU control and LED logic consume only these outputs, never raw pins.

## Interface
- `WIDTH`, 5: number of independent input bits.
- `DEBOUNCE_CYCLES`, 1000000: stability window in `clk` cycles (10 ms at 100 MHz); legal range 2 to 2^`CNT_W`-1; simulation uses 4–10.
- `CNT_W`, 20: width of each per-bit debounce counter.

- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `btn_in`  input  WIDTH  raw asynchronous button/switch levels.
- `btn_stable`  output  WIDTH  debounced level.
- `btn_rise`  output  WIDTH  one-cycle pulse on debounced 0→1.
- `btn_fall`  output  WIDTH  one-cycle pulse on debounced 1→0.
- `btn_toggle`  output  WIDTH  flips on every debounced rise.

## Operation
- Every bit has its own independent logic. There is no cross-bit interaction.
- Synchroniser: two flops per bit, `sync1 <= btn_in`, `sync2 <= sync1`. Only `sync2` feeds the debounce logic.
- Per-bit state is one counter `cnt[CNT_W-1:0]` and one stable register. Behaviour per edge:
  - `sync2 == btn_stable`: `cnt <= 0`, no pulse.
  - `sync2 != btn_stable` and `cnt != DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `sync2 != btn_stable` and `cnt == DEBOUNCE_CYCLES-1`: `btn_stable <= sync2`, `cnt <= 0`, assert `btn_rise` (if `sync2`=1) or `btn_fall` (if 0) for that one cycle. On rise, `btn_toggle <= ~btn_toggle`.
- Glitch rejection: any return of `sync2` to the stable level before the window completes clears `cnt`. The window restarts from zero on the next difference.
- `btn_rise` and `btn_fall` are registered. They are never both high on the same bit, and are deasserted on the edge following assertion.
- Counter arithmetic: unsigned, no wrap possible because `cnt` never exceeds `DEBOUNCE_CYCLES-1`.
- Reset (synchronous, any time, including mid-window): `sync1`, `sync2`, `cnt`, `btn_stable`, `btn_rise`, `btn_fall`, `btn_toggle` all go to 0 at the reset edge. In-flight windows and pending pulses are discarded.
- Input held high across reset release: it is treated as a fresh press. After the full latency, `btn_rise` pulses and `btn_toggle` sets.

## Timing
- Reset values of all outputs: 0.
- Latency: `btn_in` changes before edge 0 and is held. `sync1` updates at edge 0, `sync2` at edge 1. `btn_stable` changes and the pulse asserts at edge `DEBOUNCE_CYCLES`+1. The pulse clears at edge `DEBOUNCE_CYCLES`+2.
- Minimum accepted input level duration: `DEBOUNCE_CYCLES` cycles as seen at `sync2`. Shorter levels produce no output change.
- Simultaneous transitions on several bits: each bit is handled independently. Pulses may coincide on the same cycle.
- Reset asserted on the same edge a pulse would fire: reset wins and no pulse is produced.

## Test plan
All scenarios use `WIDTH`=5 and `DEBOUNCE_CYCLES`=4.

- **Reset:** assert `reset` for 2 cycles with `btn_in`=5'b11111. At the reset edge all outputs read 0. Release reset: `btn_stable`=5'b11111, `btn_rise`=5'b11111 for exactly one cycle at the 5th edge after `sync1` samples, and `btn_toggle`=5'b11111.
- **Clean press/release on bit 0:** `btn_in[0]` 0→1 before edge 0. `btn_stable[0]`=1 and `btn_rise[0]`=1 at edge 5, `btn_rise[0]`=0 at edge 6. Release after 20 cycles: `btn_fall[0]` pulses once 5 edges later, `btn_toggle[0]` stays 1.
- **Bounce:** `btn_in[1]` toggles 1,0,1,0,1 with 2 cycles per level, then holds 1. No output change during bouncing. A single `btn_rise[1]` occurs 5 edges after the final transition.
- **Short glitch:** a 3-cycle high pulse on `btn_in[2]` produces no `btn_rise`, no `btn_fall`, and `btn_stable[2]` stays 0.
- **Toggle and independence:** two full press/release cycles on bit 3 while bit 4 presses concurrently. `btn_toggle[3]` goes 1 then 0. Bit 4 produces its own independent rise, and the bit-4 rise coincides with the bit-3 rise when the inputs are aligned.
- **Reset mid-window:** start a press on bit 0, assert `reset` at cycle 3 of the window. No pulse is produced, the counter is cleared, and the held input yields `btn_rise` 5 edges after reset release.
